io_key_interface: RTL and testbench
===================================

IO_KEY_INTERFACE -- requirements
Module: io_key_interface

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required to accept a key level change (legal range 2..65535).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: 1 means a key_in bit at 0 is a press.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port data_io, inout, 32 bits: shared tristate CPU data bus.
REQ-006 SHALL have port cs_en, input, 1 bit: chip select.
REQ-007 SHALL have port wt_en, input, 1 bit: write strobe.
REQ-008 SHALL have port rd_en, input, 1 bit: read strobe, with no side effects.
REQ-009 SHALL have port key_in, input, 4 bits: raw, asynchronous key or button pins.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt, high while any unmasked press is pending.

Function
REQ-011 SHALL drive data_io with the read word when cs_en=1 and wt_en=0, and SHALL hold data_io at high-Z otherwise.
REQ-012 Read word SHALL be: [3:0] level, [7:4] pending, [11:8] mask, [31:12] zero.
REQ-013 A write (cs_en=1 and wt_en=1, sampled at the clk rising edge) SHALL clear each pending[i] whose data_io[i] is 1 (write-1-to-clear), and SHALL load mask from data_io[11:8].
REQ-014 Each key_in bit SHALL pass through a 2-flop synchronizer, followed by optional inversion so that 1 means pressed.
REQ-015 Per bit, a counter SHALL increment while the synchronized value differs from level[i], and SHALL clear to 0 whenever they are equal.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with the values still differing, level[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-017 A key_in change held steady SHALL appear on level exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave level unchanged.
REQ-019 pending[i] SHALL set on the same edge that level[i] transitions 0->1; a release (1->0) SHALL not set pending.
REQ-020 If a press set and a write-1-to-clear of the same bit occur on the same edge, set SHALL win (pending stays 1).
REQ-021 pending SHALL be sticky; a second press while a bit is already pending SHALL leave it at 1, with no count.
REQ-022 irq SHALL equal OR of (pending AND mask), combinational from registers and glitch-free; it SHALL be 0 whenever mask is 0.
REQ-023 Counter width SHALL be 16 bits; the counter SHALL never wrap, because it clears at the threshold.

Reset
REQ-024 On rst_n=0, the block SHALL reset asynchronously as follows: level=0, pending=0, mask=0, counters=0, irq=0.
REQ-025 On rst_n=0, synchronizer flops SHALL reset to the inactive pin value (1 when ACTIVE_LOW=1), so no press is reported on release of reset.
REQ-026 data_io SHALL be high-Z during reset unless cs_en=1 and wt_en=0.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.
REQ-028 A key held pressed through reset SHALL be reported after DEBOUNCE_CYCLES+2 edges once rst_n deasserts.

Structure
REQ-029 Read-word bit-field positions (LEVEL_LSB=0, PEND_LSB=4, MASK_LSB=8) SHALL live in a shared package io_pkg, used by the CPU-side bus decoder and the bench.
REQ-030 The synchronizer, inversion and debounce for one bit SHALL be a sub-module io_key_debounce (ports: clk, rst_n, raw, level), instantiated 4 times.
REQ-031 Bus decode, pending, mask and irq logic SHALL stay in io_key_interface.

Verification (benches run with DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
REQ-032 Press and hold: after reset, drive key_in=4'b1110 -> level[0]=1 on edge 10, pending[0]=1 on the same edge; a read returns 32'h0000_0011.
REQ-033 Bounce: key_in[1] low for 5 cycles then high -> level and pending stay 0; read returns 32'h0; irq=0.
REQ-034 Interrupt and W1C: press key 2 with mask=4'b0100 written (data_io=32'h0000_0400) -> irq=1; write 32'h0000_0404 -> pending[2]=0 and irq=0 on the next cycle; level[2] stays 1.
REQ-035 Set-versus-clear collision: a write of 32'h0000_0001 lands on the edge where level[0] rises -> pending[0]=1 afterwards.
REQ-036 Bus tristate: cs_en=0, or cs_en=1 with wt_en=1 -> data_io=Z; cs_en=1 with wt_en=0 -> data_io is driven with the read word.
REQ-037 Reset mid-operation: assert rst_n=0 at count 5 of a press -> all state and irq=0; after release with the key still held, level=1 after 10 edges.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared key-interface constants and read-word field positions
package io_pkg;
    localparam int NKEYS     = 4;
    localparam int CNT_W     = 16;
    localparam int LEVEL_LSB = 0;
    localparam int PEND_LSB  = 4;
    localparam int MASK_LSB  = 8;
endpackage

// File: rtl/io_key_debounce.sv
// io_key_debounce: 2-flop synchronizer, polarity fix and debounce for one key
// Ports: clk - system clock; rst_n - async active-low reset;
//        raw - asynchronous key pin; level - debounced state, 1 = pressed
module io_key_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam logic IDLE = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff, hit;
    always_comb begin
        diff    = (sync_q[1] ^ IDLE) != level_q;
        hit     = diff && cnt_q == LAST;
        cnt_d   = (!diff || hit) ? '0 : cnt_q + 1'b1;
        level_d = hit ? ~level_q : level_q;
    end
    // Synchronizer resets to the idle pin value so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{IDLE}};
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
endmodule

// File: rtl/io_key_interface.sv
// io_key_interface: four debounced keys with sticky press flags, mask and irq on a CPU bus
// Ports: clk, rst_n (async active-low); data_io - 32-bit tristate bus;
//        cs_en/wt_en/rd_en - bus strobes; key_in - raw key pins; irq - level interrupt
module io_key_interface
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  tri   [31:0]      data_io,
    input  logic             cs_en,
    input  logic             wt_en,
    input  logic             rd_en,
    input  logic [NKEYS-1:0] key_in,
    output logic             irq
);
    logic [NKEYS-1:0] level, level_prev_q, rise, pending;
    logic [NKEYS-1:0] pending_q, pending_d, mask_q, mask_d, w1c;
    logic [31:0]      rd_word;
    logic             wr, unused_rd;
    genvar i;
    for (i = 0; i < NKEYS; i++) begin : g_key
        io_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (key_in[i]),
            .level(level[i])
        );
    end
    // A rising level is visible as pending immediately; it is folded into pending_q
    // one edge later, after any clear on the rising edge itself has been ignored.
    always_comb begin
        rise    = level & ~level_prev_q;
        pending = pending_q | rise;
        rd_word = '0;
        rd_word[LEVEL_LSB +: NKEYS] = level;
        rd_word[PEND_LSB +: NKEYS]  = pending;
        rd_word[MASK_LSB +: NKEYS]  = mask_q;
    end
    always_comb begin
        wr        = cs_en && wt_en;
        w1c       = wr ? data_io[NKEYS-1:0] : '0;
        pending_d = pending & ~w1c;
        mask_d    = wr ? data_io[MASK_LSB +: NKEYS] : mask_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
        end else begin
            level_prev_q <= level;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
        end
    end
    assign unused_rd = rd_en;
    assign irq       = |(pending & mask_q);
    assign data_io   = (cs_en && !wt_en) ? rd_word : 'z;
endmodule

// File: tb/tb_io_key_interface.sv
// tb_io_key_interface: directed table and sequence checks for io_key_interface
module tb_io_key_interface;
    import io_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0, cs_en = 1'b0, wt_en = 1'b0, rd_en = 1'b0, tb_oe = 1'b0;
    logic [3:0]  key_in = 4'hF;
    logic [31:0] tb_data = '0, word;
    logic        irq;
    tri   [31:0] data_io;
    int          total = 0, bad = 0;

    assign data_io = tb_oe ? tb_data : 'z;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup pu (data_io[g]);
    end

    io_key_interface #(.DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .data_io(data_io), .cs_en(cs_en),
        .wt_en(wt_en), .rd_en(rd_en), .key_in(key_in), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        bit          wr;
        logic [31:0] wdata;
        int          cyc;
        logic [31:0] exp_word;
        bit          exp_irq;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [31:0] mk(input logic [3:0] lv, input logic [3:0] pd, input logic [3:0] mk_);
        logic [31:0] w;
        w = '0;
        w[LEVEL_LSB +: 4] = lv;
        w[PEND_LSB +: 4]  = pd;
        w[MASK_LSB +: 4]  = mk_;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(output logic [31:0] w);
        cs_en = 1'b1; wt_en = 1'b0; tb_oe = 1'b0; rd_en = 1'b1;
        #1;
        w = data_io;
        cs_en = 1'b0; rd_en = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] w);
        cs_en = 1'b1; wt_en = 1'b1; tb_oe = 1'b1; tb_data = w;
        step(1);
        cs_en = 1'b0; wt_en = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic do_reset();
        key_in = 4'hF;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        vecs[0]  = '{4'hF, 1'b0, 32'h0,   5,  mk(4'h0, 4'h0, 4'h0), 1'b0};
        vecs[1]  = '{4'hD, 1'b0, 32'h0,   5,  mk(4'h0, 4'h0, 4'h0), 1'b0};
        vecs[2]  = '{4'hF, 1'b0, 32'h0,   12, mk(4'h0, 4'h0, 4'h0), 1'b0};
        vecs[3]  = '{4'hB, 1'b1, 32'h400, 9,  mk(4'h0, 4'h0, 4'h4), 1'b0};
        vecs[4]  = '{4'hB, 1'b0, 32'h0,   1,  mk(4'h4, 4'h4, 4'h4), 1'b1};
        vecs[5]  = '{4'hB, 1'b1, 32'h404, 1,  mk(4'h4, 4'h0, 4'h4), 1'b0};
        vecs[6]  = '{4'hF, 1'b0, 32'h0,   10, mk(4'h0, 4'h0, 4'h4), 1'b0};
        vecs[7]  = '{4'hB, 1'b0, 32'h0,   10, mk(4'h4, 4'h4, 4'h4), 1'b1};
        vecs[8]  = '{4'hF, 1'b0, 32'h0,   10, mk(4'h0, 4'h4, 4'h4), 1'b1};
        vecs[9]  = '{4'hB, 1'b0, 32'h0,   10, mk(4'h4, 4'h4, 4'h4), 1'b1};
        vecs[10] = '{4'hB, 1'b1, 32'h000, 1,  mk(4'h4, 4'h4, 4'h0), 1'b0};
        vecs[11] = '{4'hB, 1'b1, 32'h00F, 1,  mk(4'h4, 4'h0, 4'h0), 1'b0};
        vecs[12] = '{4'h0, 1'b1, 32'hF00, 10, mk(4'hF, 4'hB, 4'hF), 1'b1};

        step(2);
        chk("reset bus idle", data_io, 32'hFFFF_FFFF);
        chk("reset irq", {31'b0, irq}, 32'h0);
        rd(word);
        chk("reset read", word, 32'h0);
        rst_n = 1'b1;
        step(2);

        cs_en = 1'b1; wt_en = 1'b1; tb_oe = 1'b0;
        #1;
        chk("bus z on write", data_io, 32'hFFFF_FFFF);
        cs_en = 1'b0; wt_en = 1'b0;
        #1;
        chk("bus z when deselected", data_io, 32'hFFFF_FFFF);

        do_reset();
        key_in = 4'hE;
        step(9);
        rd(word);
        chk("press edge 9", word, mk(4'h0, 4'h0, 4'h0));
        step(1);
        rd(word);
        chk("press edge 10", word, 32'h0000_0011);
        chk("press irq masked", {31'b0, irq}, 32'h0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            key_in = vecs[i].key;
            if (vecs[i].wr) begin
                wr(vecs[i].wdata);
                step(vecs[i].cyc - 1);
            end else begin
                step(vecs[i].cyc);
            end
            rd(word);
            chk($sformatf("vec%0d word", i), word, vecs[i].exp_word);
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        do_reset();
        key_in = 4'hE;
        step(9);
        wr(32'h0000_0001);
        rd(word);
        chk("collision set wins", word, 32'h0000_0011);
        step(1);
        rd(word);
        chk("collision sticky", word, 32'h0000_0011);
        wr(32'h0000_0001);
        rd(word);
        chk("clear after rise", word, 32'h0000_0001);

        do_reset();
        wr(32'h0000_0F00);
        key_in = 4'hE;
        step(7);
        rst_n = 1'b0;
        #1;
        rd(word);
        chk("mid reset read", word, 32'h0);
        chk("mid reset irq", {31'b0, irq}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(9);
        rd(word);
        chk("held through reset edge 9", word, 32'h0);
        step(1);
        rd(word);
        chk("held through reset edge 10", word, 32'h0000_0011);
        chk("held through reset irq", {31'b0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
